stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
Parametrised M-to-1 stream multiplexer with a built-in arbiter and a registered output. It generalises the team's combinational 4-to-1 mux in three ways: any channel count and width, per-channel valid/ready handshake, and selectable round-robin or fixed-priority arbitration. It sits between several producer channels and a single downstream consumer, for example shared bus or display ports.

Parameters:
N, 8, data width per channel in bits (N >= 1)
M, 4, number of input channels (M >= 2; need not be a power of two)
SELW, $clog2(M), width of the channel index (localparam, not overridable)

Ports:
clk  input  1  clock; all logic is rising-edge
rst_n  input  1  synchronous active-low reset
in_data  input  M*N  flattened channel data; channel k occupies bits [k*N +: N]
in_valid  input  M  per-channel valid
in_ready  output  M  per-channel ready; one-hot or zero
mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
out_data  output  N  registered output data
out_valid  output  1  registered output valid
out_ready  input  1  downstream ready
out_sel  output  SELW  index of the channel that supplied out_data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). When rst_n is sampled low at a rising edge, the following take their reset values:
  - out_valid = 0, out_data = 0, out_sel = 0
  - round-robin pointer = 0, so channel 0 has top priority first
- in_ready is forced to 0 combinationally whenever rst_n = 0.
- Handshake: a transfer occurs on a channel or the output when valid and ready are both 1 at a rising edge. Sources must hold data and valid stable until accepted.
- Load condition: load = rst_n and (!out_valid or out_ready). This is a single output register stage with no skid buffer.
- Grant: when load = 1 and in_valid is nonzero, exactly one channel g is granted. in_ready[g] = 1 in that same cycle, combinationally. All other in_ready bits are 0. When load = 0 or in_valid = 0, in_ready = 0.
- Mode 1 (fixed priority): g = the lowest index with in_valid set.
- Mode 0 (round-robin): g = the first index with in_valid set, searching from ptr upward modulo M.
- Round-robin pointer: on each grant (in either mode), ptr <= g+1. When g = M-1, ptr wraps to 0; this also holds for non-power-of-two M.
  - ptr is unchanged in cycles with no grant.
  - A change of mode takes effect on the same cycle's arbitration; ptr is retained across the change.
- Output update on the edge following a grant: out_data <= channel g data, out_sel <= g, out_valid <= 1. Latency from input acceptance to out_valid is exactly 1 cycle.
- Load with no valid input: out_valid <= 0. out_data and out_sel hold their last values.
- Backpressure (out_valid = 1 and out_ready = 0): out_data, out_sel and out_valid hold stable, and all in_ready are 0.
- Throughput: one transfer per cycle when out_ready stays 1. There are no bubbles between back-to-back grants.
- Simultaneous events: out_ready = 1 and a new grant in the same cycle means the old word is consumed and the new word is loaded on the same edge.
- Reset mid-operation: any pending output word is discarded. The first grant after reset follows the ptr = 0 ordering.

Test Plan:
1. Reset: (N=4, M=4) hold rst_n = 0 for 2 cycles with in_valid = 4'b1111 and out_ready = 1 -> in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0 throughout.
2. Single channel: in_valid = 4'b0100, channel 2 data = 4'b0111, out_ready = 1 -> in_ready = 4'b0100 in the same cycle; next cycle out_valid = 1, out_data = 4'b0111, out_sel = 2.
3. Round-robin: mode = 0, all valid, channel k data = k+1, out_ready = 1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles with out_valid held at 1.
4. Fixed priority: mode = 1, all valid -> out_sel = 0 every cycle. Then drop in_valid[0] -> out_sel = 1. Then switch to mode = 0 -> the search continues from ptr = 2.
5. Backpressure: with out_valid = 1 and out_sel = 1, hold out_ready = 0 for 3 cycles -> out_data and out_sel stable, in_ready = 0. Release -> the next grant is channel 2.
6. Wrap and reset: M = 3, all valid, mode = 0 -> out_sel 0,1,2,0. Assert rst_n = 0 for 1 cycle after grant 1 -> out_valid = 0, and the first post-reset grant is channel 0.

Source files
------------

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: M-to-1 valid/ready stream mux with round-robin or fixed-priority arbitration, 1-cycle registered output.
// Backpressure: while out_valid && !out_ready the output register holds and no input is granted.
module stream_mux_arb #(
    parameter int N = 8,
    parameter int M = 4,
    localparam int SELW = $clog2(M)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [M*N-1:0]    in_data,
    input  logic [M-1:0]      in_valid,
    output logic [M-1:0]      in_ready,
    input  logic              mode,
    output logic [N-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_sel
);

    localparam logic [SELW-1:0] LAST = SELW'(M - 1);

    logic              load;
    logic              gnt_vld;
    logic              gnt_fire;
    logic [SELW-1:0]   gnt_idx;
    logic [SELW-1:0]   scan_idx;
    logic [N-1:0]      gnt_dat;

    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   out_sel_q, out_sel_d;
    logic [N-1:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    assign load = rst_n & (~out_valid_q | out_ready);

    // Single wrap-around scan; fixed priority is just a scan that starts at 0.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = mode ? '0 : ptr_q;
        for (int i = 0; i < M; i++) begin
            if (!gnt_vld && in_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
            scan_idx = (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
        end
        gnt_dat = in_data[gnt_idx*N +: N];
    end

    assign gnt_fire = load & gnt_vld;

    always_comb begin
        in_ready = '0;
        if (gnt_fire) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_sel_d   = out_sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (gnt_fire) begin
            ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
        if (load) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = gnt_dat;
                out_sel_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_sel_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_sel_q   <= out_sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: a 4-channel and a 3-channel instance, directed stimulus, queue scoreboard.
module tb_stream_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [15:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic        mode4, out_valid4, out_ready4;
    logic [3:0]  out_data4;
    logic [1:0]  out_sel4;

    logic [11:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3, out_valid3, out_ready3;
    logic [3:0]  out_data3;
    logic [1:0]  out_sel3;

    stream_mux_arb #(.N(4), .M(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .mode(mode4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_sel(out_sel4)
    );

    stream_mux_arb #(.N(4), .M(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_sel(out_sel3)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] dat;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    exp_t e4, e3;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output word is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4_unexpected_output: got sel %0d, expected no word", out_sel4);
            end else begin
                e4 = q4.pop_front();
                chk("dut4_out_sel", 32'(out_sel4), 32'(e4.sel));
                chk("dut4_out_data", 32'(out_data4), 32'(e4.dat));
            end
        end
        if (rst_n === 1'b1 && out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut3_unexpected_output: got sel %0d, expected no word", out_sel3);
            end else begin
                e3 = q3.pop_front();
                chk("dut3_out_sel", 32'(out_sel3), 32'(e3.sel));
                chk("dut3_out_data", 32'(out_data3), 32'(e3.dat));
            end
        end
    end

    // Each call occupies one cycle: drive, check combinational ready and current out_valid, then clock.
    task automatic drive4(input logic [3:0] v, input logic md, input logic ordy,
                          input logic [3:0] exp_rdy, input logic exp_ov, input string name);
        exp_t e;
        in_valid4  = v;
        mode4      = md;
        out_ready4 = ordy;
        #1;
        chk({name, "_in_ready"}, 32'(in_ready4), 32'(exp_rdy));
        chk({name, "_out_valid"}, 32'(out_valid4), 32'(exp_ov));
        for (int k = 0; k < 4; k++) begin
            if (exp_rdy[k]) begin
                e.sel = k[1:0];
                e.dat = in_data4[k*4 +: 4];
                q4.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic [2:0] v, input logic md, input logic ordy,
                          input logic [2:0] exp_rdy, input logic exp_ov, input string name);
        exp_t e;
        in_valid3  = v;
        mode3      = md;
        out_ready3 = ordy;
        #1;
        chk({name, "_in_ready"}, 32'(in_ready3), 32'(exp_rdy));
        chk({name, "_out_valid"}, 32'(out_valid3), 32'(exp_ov));
        for (int k = 0; k < 3; k++) begin
            if (exp_rdy[k]) begin
                e.sel = k[1:0];
                e.dat = in_data3[k*4 +: 4];
                q3.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr4_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [2:0] rr3_exp [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    initial begin
        rst_n      = 1'b0;
        in_data4   = 16'h0000;
        in_valid4  = 4'b1111;
        mode4      = 1'b0;
        out_ready4 = 1'b1;
        in_data3   = 12'h321;
        in_valid3  = 3'b000;
        mode3      = 1'b0;
        out_ready3 = 1'b1;

        // Reset held with all channels requesting
        @(posedge clk);
        #1;
        repeat (2) begin
            #1;
            chk("reset_in_ready", 32'(in_ready4), 32'h0);
            chk("reset_out_valid", 32'(out_valid4), 32'h0);
            chk("reset_out_data", 32'(out_data4), 32'h0);
            chk("reset_out_sel", 32'(out_sel4), 32'h0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Single channel: channel 2 carries 4'b0111
        in_data4 = 16'h0700;
        drive4(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "idle");
        drive4(4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, "single");
        drive4(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, "single_out");

        // Reset pulse so the round-robin run starts from ptr 0
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin, all valid, channel k data = k+1
        in_data4 = 16'h4321;
        for (int i = 0; i < 6; i++) begin
            drive4(4'b1111, 1'b0, 1'b1, rr4_exp[i], (i != 0), "rr");
        end

        // Fixed priority, then drop channel 0, then back to round-robin from ptr 2
        drive4(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, "fixed");
        drive4(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, "fixed");
        drive4(4'b1110, 1'b1, 1'b1, 4'b0010, 1'b1, "fixed_drop0");
        drive4(4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, "mode_switch");

        // Backpressure with channel 1's word sitting in the output register
        drive4(4'b1110, 1'b1, 1'b1, 4'b0010, 1'b1, "bp_load");
        repeat (3) begin
            drive4(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, "bp_hold");
            chk("bp_out_sel", 32'(out_sel4), 32'd1);
            chk("bp_out_data", 32'(out_data4), 32'd2);
        end
        drive4(4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, "bp_release");
        drive4(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, "drain4");

        // Three channels: wrap from 2 back to 0
        for (int i = 0; i < 5; i++) begin
            drive3(3'b111, 1'b0, 1'b1, rr3_exp[i], (i != 0), "wrap");
        end

        // Reset with channel 1's word still pending; it must be discarded
        out_ready3 = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("rst3_in_ready", 32'(in_ready3), 32'h0);
        chk("rst3_pending_valid", 32'(out_valid3), 32'h1);
        @(posedge clk);
        #1;
        chk("rst3_out_valid", 32'(out_valid3), 32'h0);
        chk("rst3_out_sel", 32'(out_sel3), 32'h0);
        chk("rst3_out_data", 32'(out_data3), 32'h0);
        q3.delete();
        rst_n = 1'b1;
        drive3(3'b111, 1'b0, 1'b1, 3'b001, 1'b0, "post_rst");
        drive3(3'b000, 1'b0, 1'b1, 3'b000, 1'b1, "drain3");
        drive3(3'b000, 1'b0, 1'b1, 3'b000, 1'b0, "idle3");

        chk("dut4_scoreboard_empty", 32'(q4.size()), 32'd0);
        chk("dut3_scoreboard_empty", 32'(q3.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
